// File: rtl/buffer_dump.sv
// Streams the 256-byte receive text buffer to the UART transmitter, byte by byte.
// Optional CR/LF after each buffer line when BUFFER_DUMP_NEWLINE_EN is defined.
module buffer_dump #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LINE_LEN  = 32,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dumpReq,
  input  logic       ramBusy,
  output logic [7:0] addr,
  input  logic [7:0] mem,
  output logic [7:0] txData,
  output logic       txStart,
  input  logic       txBusy,
  output logic       dumpBusy,
  output logic       dumpDone
);

  localparam logic [7:0] LAST_INDEX = 8'(DEPTH - 1);

  if ((LINE_LEN & (LINE_LEN - 1)) != 0) begin : g_bad_line_len
    $error("buffer_dump: LINE_LEN must be a power of two");
  end

  typedef enum logic [3:0] {
    IDLE,
    WAIT_RAM,
    ADDR,
    READ,
    SEND,
    WAIT_TX,
`ifdef BUFFER_DUMP_NEWLINE_EN
    NL_CR,
    NL_LF,
`endif
    DONE
  } state_t;

  state_t     state, state_next;
  logic [7:0] index;
  logic [1:0] blind_cnt;
  logic       tx_fire;
  logic [7:0] tx_byte;
  logic       load_addr;
  logic       clr_index;
  logic       advance;

`ifdef BUFFER_DUMP_NEWLINE_EN
  localparam int unsigned      COL_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);

  typedef enum logic [1:0] {PH_DATA, PH_CR, PH_LF} phase_t;

  // line_cnt tracks the column of the current index; phase records what the
  // pending WAIT_TX is waiting on so one wait state serves data, CR and LF.
  logic [COL_W-1:0] line_cnt;
  phase_t           phase, fire_phase;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_fire    = 1'b0;
    tx_byte    = txData;
    load_addr  = 1'b0;
    clr_index  = 1'b0;
    advance    = 1'b0;
`ifdef BUFFER_DUMP_NEWLINE_EN
    fire_phase = phase;
`endif
    case (state)
      IDLE: begin
        if (dumpReq) begin
          clr_index  = 1'b1;
          state_next = WAIT_RAM;
        end
      end
      WAIT_RAM: begin
        if (!ramBusy) state_next = ADDR;
      end
      ADDR: begin
        load_addr  = 1'b1;
        state_next = ramBusy ? WAIT_RAM : READ;
      end
      READ: begin
        state_next = ramBusy ? WAIT_RAM : SEND;
      end
      SEND: begin
        if (!txBusy) begin
          tx_fire    = 1'b1;
          tx_byte    = (mem == 8'h00) ? FILL_CHAR : mem;
`ifdef BUFFER_DUMP_NEWLINE_EN
          fire_phase = PH_DATA;
`endif
          state_next = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (blind_cnt == 2'd2 && !txBusy) begin
`ifdef BUFFER_DUMP_NEWLINE_EN
          if (phase == PH_DATA && line_cnt == LAST_COL) begin
            state_next = NL_CR;
          end else if (phase == PH_CR) begin
            state_next = NL_LF;
          end else
`endif
          if (index == LAST_INDEX) begin
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = WAIT_RAM;
          end
        end
      end
`ifdef BUFFER_DUMP_NEWLINE_EN
      NL_CR: begin
        if (!txBusy) begin
          tx_fire    = 1'b1;
          tx_byte    = 8'h0D;
          fire_phase = PH_CR;
          state_next = WAIT_TX;
        end
      end
      NL_LF: begin
        if (!txBusy) begin
          tx_fire    = 1'b1;
          tx_byte    = 8'h0A;
          fire_phase = PH_LF;
          state_next = WAIT_TX;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decision so reset clears them at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      index     <= '0;
      addr      <= '0;
      txData    <= '0;
      txStart   <= 1'b0;
      dumpBusy  <= 1'b0;
      dumpDone  <= 1'b0;
      blind_cnt <= '0;
`ifdef BUFFER_DUMP_NEWLINE_EN
      line_cnt  <= '0;
      phase     <= PH_DATA;
`endif
    end else begin
      txStart  <= tx_fire;
      dumpBusy <= (state_next != IDLE);
      dumpDone <= (state_next == DONE);
      if (load_addr) addr <= index;
      if (clr_index)    index <= '0;
      else if (advance) index <= index + 8'd1;
      if (tx_fire) begin
        txData    <= tx_byte;
        blind_cnt <= '0;
      end else if (state == WAIT_TX && blind_cnt != 2'd2) begin
        blind_cnt <= blind_cnt + 2'd1;
      end
`ifdef BUFFER_DUMP_NEWLINE_EN
      if (clr_index)    line_cnt <= '0;
      else if (advance) line_cnt <= line_cnt + 1'b1;
      if (tx_fire) phase <= fire_phase;
`endif
    end
  end

endmodule

// File: tb/tb_buffer_dump.sv
// Directed self-checking bench for buffer_dump with a synchronous RAM and a
// transmitter model whose busy time is programmable.
module tb_buffer_dump;

  logic       clk = 1'b0;
  logic       reset;
  logic       dumpReq;
  logic       ramBusy;
  logic [7:0] addr;
  logic [7:0] mem;
  logic [7:0] txData;
  logic       txStart;
  logic       txBusy;
  logic       dumpBusy;
  logic       dumpDone;

`ifdef BUFFER_DUMP_NEWLINE_EN
  localparam int N_EXP = 272;
`else
  localparam int N_EXP = 256;
`endif

  buffer_dump #(.DEPTH(256), .LINE_LEN(32), .FILL_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .dumpReq(dumpReq), .ramBusy(ramBusy),
    .addr(addr), .mem(mem), .txData(txData), .txStart(txStart),
    .txBusy(txBusy), .dumpBusy(dumpBusy), .dumpDone(dumpDone)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) mem <= ram[addr];

  int         tx_time = 10;
  int         tx_cnt = 0;
  logic       tx_hold = 1'b0;
  assign txBusy = (tx_cnt != 0) || tx_hold;

  logic [7:0] cap_byte[$];
  logic [7:0] cap_addr[$];
  int         viol_busy = 0;
  int         viol_width = 0;
  int         done_cnt = 0;
  logic       prev_start = 1'b0;

  always @(posedge clk) begin
    if (txStart === 1'b1) begin
      tx_cnt <= tx_time;
      cap_byte.push_back(txData);
      cap_addr.push_back(addr);
      if (txBusy) viol_busy <= viol_busy + 1;
      if (prev_start) viol_width <= viol_width + 1;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
    end
    prev_start <= txStart;
    if (dumpDone === 1'b1) done_cnt <= done_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    return (ram[i] == 8'h00) ? 8'h20 : ram[i];
  endfunction

  task automatic check_stream(input int base, input string tag);
    int k = base;
    int bad_b = 0;
    int bad_a = 0;
    check({tag, "_count"}, 32'(cap_byte.size() - base), N_EXP);
    for (int i = 0; i < 256; i++) begin
      if (k < cap_byte.size()) begin
        if (cap_byte[k] !== exp_byte(i)) bad_b++;
        if (cap_addr[k] !== 8'(i)) bad_a++;
      end else begin
        bad_b++;
      end
      k++;
`ifdef BUFFER_DUMP_NEWLINE_EN
      if (i % 32 == 31) begin
        for (int j = 0; j < 2; j++) begin
          if (k < cap_byte.size()) begin
            if (cap_byte[k] !== ((j == 0) ? 8'h0D : 8'h0A)) bad_b++;
          end else begin
            bad_b++;
          end
          k++;
        end
      end
`endif
    end
    check({tag, "_bad_bytes"}, bad_b, 0);
    check({tag, "_bad_addrs"}, bad_a, 0);
  endtask

  task automatic wait_done(input int bound, input string tag);
    int n = 0;
    while (dumpDone !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, dumpDone, 1);
  endtask

  task automatic pulse_req();
    dumpReq = 1'b1;
    @(negedge clk);
    dumpReq = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base, base2, d0, lat, n, starts, chg, cnt5;
    logic [7:0] td0, got;

    reset = 1'b1; dumpReq = 1'b0; ramBusy = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_txData", txData, 0);
    check("rst_txStart", txStart, 0);
    check("rst_dumpBusy", dumpBusy, 0);
    check("rst_dumpDone", dumpDone, 0);
    reset = 1'b0;
    @(negedge clk);

    // Cleared buffer, slow transmitter
    tx_time = 10;
    base = cap_byte.size();
    d0 = done_cnt;
    dumpReq = 1'b1;
    @(negedge clk);
    dumpReq = 1'b0;
    lat = 0;
    while (txStart !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", lat, 4);
    check("t1_first_byte", txData, 8'h20);
    wait_done(8000, "t1");
    check_stream(base, "t1");
    @(negedge clk);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_idle", dumpBusy, 0);

    // Two marked cells
    tx_time = 3;
    ram[0] = 8'h41;
    ram[31] = 8'h42;
    base = cap_byte.size();
    pulse_req();
    wait_done(8000, "t2");
    check_stream(base, "t2");
    check("t2_byte0", cap_byte[base], 8'h41);
    check("t2_byte31", cap_byte[base + 31], 8'h42);
`ifdef BUFFER_DUMP_NEWLINE_EN
    check("t2_byte32", cap_byte[base + 32], 8'h0D);
    check("t2_byte33", cap_byte[base + 33], 8'h0A);
`else
    check("t2_byte32", cap_byte[base + 32], 8'h20);
    check("t2_byte33", cap_byte[base + 33], 8'h20);
`endif
    @(negedge clk);

    // RAM stall while reading index 5
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    base = cap_byte.size();
    pulse_req();
    n = 0;
    while (addr !== 8'd5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_addr5_reached", addr, 5);
    ramBusy = 1'b1;
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (txStart === 1'b1) starts++;
    end
    ramBusy = 1'b0;
    check("t3_no_start_in_stall", starts, 0);
    wait_done(8000, "t3");
    check_stream(base, "t3");
    cnt5 = 0;
    for (int k = base; k < cap_byte.size(); k++)
      if (cap_addr[k] == 8'd5) cnt5++;
    check("t3_index5_once", cnt5, 1);
    @(negedge clk);

    // Request held high across the whole dump
    base = cap_byte.size();
    d0 = done_cnt;
    dumpReq = 1'b1;
    wait_done(8000, "t4");
    check("t4_count_at_done", 32'(cap_byte.size() - base), N_EXP);
    check("t4_busy_in_done", dumpBusy, 1);
    @(negedge clk);
    check("t4_idle_after_done", dumpBusy, 0);
    check("t4_done_pulses", done_cnt - d0, 1);
    @(negedge clk);
    check("t4_restart", dumpBusy, 1);
    dumpReq = 1'b0;
    do_reset();
    repeat (15) @(negedge clk);

    // Reset while waiting on the transmitter at index 100
    pulse_req();
    n = 0;
    while (!(txStart === 1'b1 && addr === 8'd100) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_100", addr, 100);
    reset = 1'b1;
    @(negedge clk);
    check("t5_txStart", txStart, 0);
    check("t5_dumpBusy", dumpBusy, 0);
    check("t5_addr", addr, 0);
    check("t5_dumpDone", dumpDone, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    base2 = cap_byte.size();
    pulse_req();
    wait_done(8000, "t5");
    check_stream(base2, "t5");
    @(negedge clk);

    // Transmitter busy for 500 cycles when SEND is reached
    ram[0] = 8'h5A;
    tx_hold = 1'b1;
    td0 = txData;
    pulse_req();
    starts = 0;
    chg = 0;
    repeat (500) begin
      @(negedge clk);
      if (txStart === 1'b1) starts++;
      if (txData !== td0) chg++;
    end
    check("t6_no_start_while_busy", starts, 0);
    check("t6_txData_held", chg, 0);
    check("t6_still_busy", dumpBusy, 1);
    tx_hold = 1'b0;
    starts = 0;
    got = 8'h00;
    repeat (6) begin
      @(negedge clk);
      if (txStart === 1'b1) begin
        starts++;
        got = txData;
      end
    end
    check("t6_one_pulse", starts, 1);
    check("t6_byte", got, 8'h5A);
    do_reset();

    check("start_while_busy", viol_busy, 0);
    check("start_width", viol_width, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
